// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM state encodings.
package dmem_responder_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering for dmem_responder: byte enables, store alignment, load extraction.
// Misalignment flag is only raised when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_byte_lane
    import dmem_responder_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rword_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o
);

    logic [1:0]      off;
    logic [XLEN-1:0] mask;

    // Offset is the truncated lane position: halves keep addr[1], words ignore addr[1:0].
    always_comb begin
        off  = 2'b00;
        be_o = 4'b0000;
        mask = '0;
        case (mem_size_e'(size_i))
            MEM_BYTE: begin
                off  = addr_lo_i;
                be_o = 4'b0001 << addr_lo_i;
                mask = 32'h0000_00FF;
            end
            MEM_HALF: begin
                off  = {addr_lo_i[1], 1'b0};
                be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                mask = 32'h0000_FFFF;
            end
            MEM_WORD: begin
                be_o = 4'b1111;
                mask = 32'hFFFF_FFFF;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
        wdata_o = wdata_i << {off, 3'b000};
        rdata_o = (rword_i >> {off, 3'b000}) & mask;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_o = ((size_i == MEM_HALF) && addr_lo_i[0]) ||
                        ((size_i == MEM_WORD) && (addr_lo_i != 2'b00));
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, store/read at accept, response after LATENCY.
// Optional misaligned-access errors via DMEM_MISALIGN_CHECK_EN (see dmem_byte_lane).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 2048,
    parameter int unsigned LATENCY  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int unsigned IdxW = $clog2(MEM_SIZE);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] StIdle = DMEM_IDLE;
    localparam logic [1:0] StWait = DMEM_WAIT;
    localparam logic [1:0] StResp = DMEM_RESP;

    logic [XLEN-1:0] mem [MEM_SIZE];

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [IdxW-1:0] idx;
    logic            oob;
    logic            req_err;
    logic            accept;
    logic [XLEN-1:0] rword;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;
    logic            lane_misalign;

    assign idx     = req_addr_i[IdxW+1:2];
    assign oob     = |req_addr_i[XLEN-1:IdxW+2];
    assign rword   = mem[idx];
    assign req_err = oob || (req_size_i == 2'b11) || lane_misalign;
    assign accept  = req_valid_i && (state_q == StIdle);

    dmem_byte_lane u_lane (
        .size_i     (req_size_i),
        .addr_lo_i  (req_addr_i[1:0]),
        .wdata_i    (req_wdata_i),
        .rword_i    (rword),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (lane_misalign)
    );

    // RAM is not reset; a store commits on the accept edge so the next load sees it.
    always_ff @(posedge clk_i) begin
        if (accept && req_we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    // Counter is loaded with 1 at accept so that the accept cycle counts towards LATENCY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    cnt_d   = CntW'(1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == CntW'(LATENCY - 1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rdata_q <= (req_we_i || req_err) ? '0 : lane_rdata;
                err_q   <= req_err;
            end
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table driven through a response scoreboard.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned LAT  = 2;
    localparam int unsigned MSZ  = 2048;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .MEM_SIZE (MSZ),
        .LATENCY  (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input string name);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.name = name;
        vecs.push_back(v);
    endfunction

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic xact(input vec_t v, input int hold);
        exp_t e;
        int   n;
        check({v.name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        e.rdata = v.rdata;
        e.err   = v.err;
        sb.push_back(e);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({v.name, " latency"}, 32'(n), 32'(LAT));
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({v.name, " rdata"}, rsp_rdata, e.rdata);
            check({v.name, " err"}, 32'(rsp_err), 32'(e.err));
            if (hold > 0) begin
                // A competing store offered while the response is stalled must be ignored.
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_size  = MEM_WORD;
                req_addr  = 32'h40;
                req_wdata = 32'hBADBAD00;
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk); #1;
                    check({v.name, " hold valid"}, 32'(rsp_valid), 32'd1);
                    check({v.name, " hold rdata"}, rsp_rdata, e.rdata);
                    check({v.name, " hold ready"}, 32'(req_ready), 32'd0);
                end
                req_valid = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({v.name, " ready after"}, 32'(req_ready), 32'd1);
            check({v.name, " valid after"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        vec_t v;

        add(1'b1, MEM_WORD, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, "sw 0x10");
        add(1'b0, MEM_WORD, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, "lw 0x10");
        add(1'b1, MEM_WORD, 32'h20,   32'h11223344, 32'h0,        1'b0, "sw 0x20");
        add(1'b1, MEM_BYTE, 32'h21,   32'h000000AA, 32'h0,        1'b0, "sb 0x21");
        add(1'b0, MEM_HALF, 32'h22,   32'h0,        32'h00001122, 1'b0, "lh 0x22");
        add(1'b0, MEM_WORD, 32'h20,   32'h0,        32'h1122AA44, 1'b0, "lw 0x20");
        add(1'b0, MEM_BYTE, 32'h21,   32'h0,        32'h000000AA, 1'b0, "lb 0x21");
        add(1'b1, MEM_WORD, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0, "sw 0x0");
        add(1'b1, MEM_WORD, 32'h2000, 32'h12345678, 32'h0,        1'b1, "sw oob");
        add(1'b0, MEM_WORD, 32'h2000, 32'h0,        32'h0,        1'b1, "lw oob");
        add(1'b1, 2'b11,    32'h0,    32'hFFFFFFFF, 32'h0,        1'b1, "sw rsvd");
        add(1'b0, 2'b11,    32'h0,    32'h0,        32'h0,        1'b1, "lw rsvd");
        add(1'b0, MEM_WORD, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, "lw 0x0 intact");
        add(1'b1, MEM_WORD, 32'h30,   32'h0,        32'h0,        1'b0, "sw 0x30");
        add(1'b1, MEM_WORD, 32'h33,   32'h55,       32'h0,        MIS,  "sw 0x33");
        add(1'b0, MEM_WORD, 32'h30,   32'h0,        MIS ? 32'h0 : 32'h55, 1'b0, "lw 0x30");
        add(1'b1, MEM_HALF, 32'h12,   32'h0000BEEF, 32'h0,        1'b0, "sh 0x12");
        add(1'b0, MEM_WORD, 32'h10,   32'h0,        32'hBEEFBEEF, 1'b0, "lw 0x10 half");
        add(1'b0, MEM_BYTE, 32'h13,   32'h0,        32'h000000BE, 1'b0, "lb 0x13");

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset rdata", rsp_rdata, 32'h0);
        check("post-reset err", 32'(rsp_err), 32'd0);

        foreach (vecs[i]) xact(vecs[i], 0);

        // Stalled response: store offered during the stall must not land.
        add(1'b1, MEM_WORD, 32'h40, 32'h01020304, 32'h0,        1'b0, "sw 0x40");
        add(1'b0, MEM_WORD, 32'h20, 32'h0,        32'h1122AA44, 1'b0, "lw 0x20 stall");
        add(1'b0, MEM_WORD, 32'h40, 32'h0,        32'h01020304, 1'b0, "lw 0x40");
        xact(vecs[vecs.size()-3], 0);
        xact(vecs[vecs.size()-2], 5);
        xact(vecs[vecs.size()-1], 0);

        // Reset while waiting on a committed store.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = MEM_WORD;
        req_addr  = 32'h50;
        req_wdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid reset valid", 32'(rsp_valid), 32'd0);
        check("mid reset ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        v.we = 1'b0; v.size = MEM_WORD; v.addr = 32'h50; v.wdata = 32'h0;
        v.rdata = 32'h5A5A5A5A; v.err = 1'b0; v.name = "lw 0x50 after reset";
        xact(v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
